// File: rtl/vec_dot_sequencer_pkg.sv
// Shared definitions for the dot-product sequencer and its lane packer:
// the sequencer state encoding, the default vector geometry used by the PE,
// and a counter-width helper that stays sane for single-lane vectors.
package vec_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } seq_state_e;

    localparam int VEC_C       = 8;
    localparam int VEC_W_X     = 8;
    localparam int VEC_W_K     = 8;
    localparam int VEC_TIMEOUT = 16;

    // Ceiling log2 that returns 0 for n <= 1, so callers add 1 to get a width.
    function automatic int clog2_safe(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/vec_dot_sequencer_lane_packer.sv
// Serial-to-parallel lane register file for the dot-product sequencer.
// Writes one (x, k) pair into the lane selected by wr_idx; when pad is set
// with the write, every lane above wr_idx is zeroed in the same cycle.
// clear wipes all lanes once a result has been handed off.
module vec_lane_packer
    import vec_pkg::*;
#(
    parameter int C   = VEC_C,
    parameter int W_X = VEC_W_X,
    parameter int W_K = VEC_W_K,
    parameter int CW  = clog2_safe(VEC_C) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [CW-1:0]    wr_idx,
    input  logic [W_X-1:0]   wr_x,
    input  logic [W_K-1:0]   wr_k,
    input  logic             pad,
    input  logic             clear,
    output logic [C*W_X-1:0] lanes_x,
    output logic [C*W_K-1:0] lanes_k
);

    logic [C*W_X-1:0] x_q;
    logic [C*W_K-1:0] k_q;

    // Lane storage: clear has priority, then the indexed write with optional padding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            k_q <= '0;
        end else if (clear) begin
            x_q <= '0;
            k_q <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < C; i++) begin
                if (CW'(i) == wr_idx) begin
                    x_q[i*W_X +: W_X] <= wr_x;
                    k_q[i*W_K +: W_K] <= wr_k;
                end else if (pad && (CW'(i) > wr_idx)) begin
                    x_q[i*W_X +: W_X] <= '0;
                    k_q[i*W_K +: W_K] <= '0;
                end
            end
        end
    end

    assign lanes_x = x_q;
    assign lanes_k = k_q;

endmodule

// File: rtl/vec_dot_sequencer.sv
// Dot-product sequencer: packs a serial (x, k) stream into C-lane vectors,
// holds pe_enable until the PE answers with pe_valid, captures pe_y and
// offers it on a valid/ready result port.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1; the source keeps its payload stable while valid && !ready, and
// ready never depends combinationally on valid.
//
// Optional macro VEC_DOT_SEQ_TIMEOUT_EN: abort a job after TIMEOUT cycles in
// WAIT with res_err = 1 and res_data = 0. Without it WAIT lasts until
// pe_valid and res_err is constant 0.
module vec_dot_sequencer
    import vec_pkg::*;
#(
    parameter int C       = VEC_C,
    parameter int W_X     = VEC_W_X,
    parameter int W_K     = VEC_W_K,
    parameter int TIMEOUT = VEC_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W_X-1:0]   in_x,
    input  logic [W_K-1:0]   in_k,
    input  logic             in_last,
    output logic             pe_enable,
    output logic [C*W_X-1:0] pe_x,
    output logic [C*W_K-1:0] pe_k,
    input  logic             pe_valid,
    input  logic [W_X-1:0]   pe_y,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [W_X-1:0]   res_data,
    output logic             res_err
);

    localparam int            CW       = clog2_safe(C) + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(C - 1);

    seq_state_e     state;
    seq_state_e     state_d;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_d;
    logic [W_X-1:0] res_data_q;
    logic [W_X-1:0] res_data_d;
    logic           wr_en;
    logic           clear;
    logic           timeout_hit;

    // Outputs are plain decodes of the state register, so a reset drops
    // pe_enable immediately and nothing depends on in_valid combinationally.
    assign in_ready  = (state == FILL);
    assign pe_enable = (state == ISSUE) || (state == WAIT);
    assign res_valid = (state == OUT);
    assign res_data  = res_data_q;

`ifdef VEC_DOT_SEQ_TIMEOUT_EN
    localparam int TW = clog2_safe(TIMEOUT) + 1;

    logic [TW-1:0] wait_cnt;
    logic          res_err_q;

    assign timeout_hit = (wait_cnt == TW'(TIMEOUT - 1));
    assign res_err     = res_err_q;

    // Cycles spent in WAIT; restarts from zero on every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + TW'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    // Error flag: set on abort, cleared when the result is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_err_q <= 1'b0;
        end else if ((state == WAIT) && !pe_valid && timeout_hit) begin
            res_err_q <= 1'b1;
        end else if ((state == OUT) && res_ready) begin
            res_err_q <= 1'b0;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT != 0);
    assign timeout_hit    = 1'b0;
    assign res_err        = 1'b0;
`endif

    // State, lane counter and captured result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FILL;
            cnt        <= '0;
            res_data_q <= '0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            res_data_q <= res_data_d;
        end
    end

    // Next-state logic; pe_valid outside WAIT is deliberately ignored.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        res_data_d = res_data_q;
        wr_en      = 1'b0;
        clear      = 1'b0;
        case (state)
            FILL: begin
                if (in_valid) begin
                    wr_en = 1'b1;
                    cnt_d = cnt + CW'(1);
                    if ((cnt == LAST_IDX) || in_last) begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (pe_valid) begin
                    res_data_d = pe_y;
                    state_d    = OUT;
                end else if (timeout_hit) begin
                    res_data_d = '0;
                    state_d    = OUT;
                end
            end
            OUT: begin
                if (res_ready) begin
                    clear   = 1'b1;
                    cnt_d   = '0;
                    state_d = FILL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    vec_lane_packer #(
        .C   (C),
        .W_X (W_X),
        .W_K (W_K),
        .CW  (CW)
    ) u_packer (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_idx  (cnt),
        .wr_x    (in_x),
        .wr_k    (in_k),
        .pad     (in_last),
        .clear   (clear),
        .lanes_x (pe_x),
        .lanes_k (pe_k)
    );

endmodule

// File: tb/tb_vec_dot_sequencer.sv
// Directed bench for vec_dot_sequencer with a behavioural dot-product PE.
// Inputs change on the falling edge or 1 ns after the rising edge; outputs
// are sampled at the same points, away from the active edge.
module tb_vec_dot_sequencer;

    localparam int C   = 8;
    localparam int W_X = 8;
    localparam int W_K = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W_X-1:0]   in_x = '0;
    logic [W_K-1:0]   in_k = '0;
    logic             in_last = 1'b0;
    logic             pe_enable;
    logic [C*W_X-1:0] pe_x;
    logic [C*W_K-1:0] pe_k;
    logic             pe_valid;
    logic [W_X-1:0]   pe_y;
    logic             res_valid;
    logic             res_ready = 1'b1;
    logic [W_X-1:0]   res_data;
    logic             res_err;

    int asserts  = 0;
    int failures = 0;
    int cyc      = 0;
    int pe_lat   = 2;
    bit pe_never = 1'b0;
    int pe_cnt;
    bit pe_done;

    vec_dot_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_k      (in_k),
        .in_last   (in_last),
        .pe_enable (pe_enable),
        .pe_x      (pe_x),
        .pe_k      (pe_k),
        .pe_valid  (pe_valid),
        .pe_y      (pe_y),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_err   (res_err)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] dot(input logic [C*W_X-1:0] x, input logic [C*W_K-1:0] k);
        int s;
        int a;
        int b;
        s = 0;
        for (int i = 0; i < C; i++) begin
            a = $signed(x[i*W_X +: W_X]);
            b = $signed(k[i*W_K +: W_K]);
            s = s + a * b;
        end
        return s[7:0];
    endfunction

    // PE model: pulses pe_valid once pe_enable has been sampled high pe_lat times
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe_valid <= 1'b0;
            pe_y     <= '0;
            pe_cnt   <= 0;
            pe_done  <= 1'b0;
        end else begin
            pe_valid <= 1'b0;
            if (!pe_enable) begin
                pe_cnt  <= 0;
                pe_done <= 1'b0;
            end else if (!pe_done && !pe_never) begin
                pe_cnt <= pe_cnt + 1;
                if (pe_cnt + 1 == pe_lat) begin
                    pe_valid <= 1'b1;
                    pe_y     <= dot(pe_x, pe_k);
                    pe_done  <= 1'b1;
                end
            end
        end
    end

    // Driver: one pair, held until accepted; returns 1 ns after the accepting edge
    task automatic send_pair(input logic [7:0] x, input logic [7:0] k, input bit last);
        @(negedge clk);
        in_valid = 1'b1;
        in_x     = x;
        in_k     = k;
        in_last  = last;
        for (int i = 0; i < 200 && !in_ready; i++) @(negedge clk);
        if (!in_ready) begin
            $display("FAIL send_pair: in_ready=%b, required 1 within 200 cycles", in_ready);
            $fatal(1, "input stalled");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Driver: n pairs with x = x0 + i*xstep, constant k, in_last on the final one
    task automatic send_vec(input int n, input int x0, input int xstep, input logic [7:0] k,
                            output int acc);
        for (int i = 0; i < n; i++) begin
            send_pair(8'(x0 + i * xstep), k, (i == n - 1));
        end
        acc = cyc;
    endtask

    task automatic wait_res(output int r);
        r = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (res_valid) begin
                r = cyc;
                return;
            end
        end
        $display("FAIL wait_res: res_valid=%b, required 1 within 200 cycles", res_valid);
        $fatal(1, "result never arrived");
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        asserts++; if (pe_enable !== 1'b0) begin failures++; $display("FAIL reset_pe_enable: got %b want 0", pe_enable); end
        asserts++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
        asserts++; if (res_data !== 8'h00) begin failures++; $display("FAIL reset_res_data: got %h want 00", res_data); end
        asserts++; if (res_err !== 1'b0) begin failures++; $display("FAIL reset_res_err: got %b want 0", res_err); end
        asserts++; if (pe_x !== 64'h0 || pe_k !== 64'h0) begin failures++; $display("FAIL reset_lanes: got x=%h k=%h want 0", pe_x, pe_k); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        asserts++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_full_vector();
        int acc;
        int r;
        res_ready = 1'b1;
        pe_lat    = 2;
        send_vec(8, 1, 1, 8'h02, acc);
        asserts++; if (pe_enable !== 1'b1) begin failures++; $display("FAIL full_pe_enable: got %b want 1", pe_enable); end
        asserts++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
        asserts++; if (pe_x !== 64'h0807060504030201) begin failures++; $display("FAIL full_pe_x: got %h want 0807060504030201", pe_x); end
        asserts++; if (pe_k !== 64'h0202020202020202) begin failures++; $display("FAIL full_pe_k: got %h want 0202020202020202", pe_k); end
        wait_res(r);
        asserts++; if (r - acc !== 3) begin failures++; $display("FAIL full_latency: got %0d edges want 3", r - acc); end
        asserts++; if (res_data !== 8'd72) begin failures++; $display("FAIL full_res_data: got %0d want 72", res_data); end
        asserts++; if (res_err !== 1'b0) begin failures++; $display("FAIL full_res_err: got %b want 0", res_err); end
        @(negedge clk);
        asserts++; if (res_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL full_after_accept: got res_valid=%b in_ready=%b want 0/1", res_valid, in_ready); end
        asserts++; if (pe_x !== 64'h0 || pe_k !== 64'h0) begin failures++; $display("FAIL full_lanes_cleared: got x=%h k=%h want 0", pe_x, pe_k); end
    endtask

    task automatic test_partial_vector();
        int acc;
        int r;
        send_vec(3, 3, 0, 8'hFE, acc);
        asserts++; if (pe_x !== 64'h0000000000030303) begin failures++; $display("FAIL partial_pe_x: got %h want 0000000000030303", pe_x); end
        asserts++; if (pe_k !== 64'h0000000000FEFEFE) begin failures++; $display("FAIL partial_pe_k: got %h want 0000000000fefefe", pe_k); end
        wait_res(r);
        asserts++; if (res_data !== 8'hEE) begin failures++; $display("FAIL partial_res_data: got %h want ee", res_data); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int acc;
        int r;
        res_ready = 1'b0;
        send_vec(8, 1, 1, 8'h01, acc);
        wait_res(r);
        // Offer the next pair while the result is stalled; it must wait.
        in_valid = 1'b1;
        in_x     = 8'h55;
        in_k     = 8'h01;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            asserts++; if (res_valid !== 1'b1 || res_data !== 8'h24 || in_ready !== 1'b0) begin
                failures++; $display("FAIL bp_stall_%0d: got res_valid=%b res_data=%h in_ready=%b want 1/24/0", i, res_valid, res_data, in_ready);
            end
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        asserts++; if (in_ready !== 1'b1 || pe_x !== 64'h0) begin failures++; $display("FAIL bp_handshake: got in_ready=%b pe_x=%h want 1/0", in_ready, pe_x); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        asserts++; if (pe_enable !== 1'b1 || pe_x !== 64'h55) begin failures++; $display("FAIL bp_next_vector: got pe_enable=%b pe_x=%h want 1/55", pe_enable, pe_x); end
        wait_res(r);
        asserts++; if (res_data !== 8'h55) begin failures++; $display("FAIL bp_next_result: got %h want 55", res_data); end
        @(negedge clk);
    endtask

    task automatic test_slow_pe();
        int acc;
        int en;
        bit unstable;
        pe_lat   = 12;
        en       = 0;
        unstable = 1'b0;
        send_vec(8, 1, 1, 8'hFF, acc);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!pe_enable) break;
            en++;
            if (pe_x !== 64'h0807060504030201 || pe_k !== 64'hFFFFFFFFFFFFFFFF) unstable = 1'b1;
        end
        asserts++; if (en !== 13) begin failures++; $display("FAIL slow_enable_cycles: got %0d want 13", en); end
        asserts++; if (unstable !== 1'b0) begin failures++; $display("FAIL slow_operands_stable: got unstable=%b want 0", unstable); end
        asserts++; if (res_valid !== 1'b1 || res_data !== 8'hDC) begin failures++; $display("FAIL slow_result: got res_valid=%b res_data=%h want 1/dc", res_valid, res_data); end
        @(negedge clk);
        asserts++; if (pe_enable !== 1'b0 || res_valid !== 1'b0) begin failures++; $display("FAIL slow_gap: got pe_enable=%b res_valid=%b want 0/0", pe_enable, res_valid); end
        pe_lat = 2;
    endtask

    task automatic test_reset_mid();
        int acc;
        int r;
        pe_never = 1'b1;
        send_vec(8, 1, 1, 8'h02, acc);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        asserts++; if (pe_enable !== 1'b0) begin failures++; $display("FAIL rstmid_pe_enable: got %b want 0", pe_enable); end
        asserts++; if (pe_x !== 64'h0 || res_valid !== 1'b0) begin failures++; $display("FAIL rstmid_discard: got pe_x=%h res_valid=%b want 0/0", pe_x, res_valid); end
        @(negedge clk);
        rst_n    = 1'b1;
        pe_never = 1'b0;
        #1;
        asserts++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
        send_vec(8, 1, 1, 8'h03, acc);
        wait_res(r);
        asserts++; if (res_data !== 8'h6C) begin failures++; $display("FAIL rstmid_result: got %h want 6c", res_data); end
        @(negedge clk);
    endtask

`ifdef VEC_DOT_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int acc;
        int r;
        pe_never  = 1'b1;
        res_ready = 1'b0;
        send_vec(8, 1, 1, 8'h02, acc);
        wait_res(r);
        asserts++; if (r - acc !== 17) begin failures++; $display("FAIL timeout_latency: got %0d edges want 17", r - acc); end
        asserts++; if (res_err !== 1'b1 || res_data !== 8'h00) begin failures++; $display("FAIL timeout_result: got err=%b data=%h want 1/00", res_err, res_data); end
        res_ready = 1'b1;
        @(negedge clk);
        asserts++; if (res_err !== 1'b0 || res_valid !== 1'b0) begin failures++; $display("FAIL timeout_clear: got err=%b res_valid=%b want 0/0", res_err, res_valid); end
        pe_never = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_full_vector();
        test_partial_vector();
        test_backpressure();
        test_slow_pe();
        test_reset_mid();
`ifdef VEC_DOT_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
